// File: rtl/ecg_uart_scheduler.sv
// ecg_uart_scheduler
//   Packetises ECG samples and heart-rate / RR-interval readings from the
//   MAX30003 driver into framed byte streams. It also shares the single uart_tx
//   transmitter between the two sources, one whole frame at a time.
//
//   Frame layout (the checksum is the XOR of the type byte and the payload):
//     ECG : SYNC, TYPE_ECG, s[23:16], s[15:8], s[7:0], chk          (6 bytes)
//     HR  : SYNC, TYPE_HR, hr[15:8], hr[7:0], rr[15:8], rr[7:0], chk (7 bytes)
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   en           1 = new frames may start; 0 = finish the current frame, then hold
//   ecg_valid    1-cycle strobe, ecg_sample valid
//   ecg_sample   24-bit ECG sample
//   hr_valid     1-cycle strobe, heart_rate / rr_interval valid
//   heart_rate   16-bit heart rate
//   rr_interval  16-bit RR interval
//   tx_busy      uart_tx busy
//   tx_start     1-cycle pulse, uart_tx loads tx_data
//   tx_data      byte to transmit, held from tx_start until tx_busy falls
//   frame_done   1-cycle pulse after the last byte of a frame completes
//   drop_cnt     count of pending samples lost to overwrite, saturates at 255
module ecg_uart_scheduler #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] TYPE_ECG  = 8'h01,
  parameter logic [7:0] TYPE_HR   = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ecg_valid,
  input  logic [23:0] ecg_sample,
  input  logic        hr_valid,
  input  logic [15:0] heart_rate,
  input  logic [15:0] rr_interval,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_done,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [23:0] ecgData_q, ecgData_d;
  logic        ecgFull_q, ecgFull_d;
  logic [31:0] hrData_q, hrData_d;
  logic        hrFull_q, hrFull_d;
  logic        selHr_q, selHr_d;
  logic [7:0]  frame_q [0:6];
  logic [7:0]  frame_d [0:6];
  logic [2:0]  lastIdx_q, lastIdx_d;
  logic [2:0]  idx_q, idx_d;
  logic        txStart_q, txStart_d;
  logic [7:0]  txData_q, txData_d;
  logic        frameDone_q, frameDone_d;
  logic [7:0]  dropCnt_q, dropCnt_d;

  logic        consumeEcg;
  logic        consumeHr;
  logic [1:0]  dropInc;
  logic [8:0]  dropSum;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The transmitter is handed one byte at a time. Each byte
  // waits for the busy flag to rise and then fall before the next one goes out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en && (ecgFull_q || hrFull_q)) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (!tx_busy) state_d = WAIT_HI;
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_d = (idx_q == lastIdx_q) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    ecgData_d   = ecgData_q;
    ecgFull_d   = ecgFull_q;
    hrData_d    = hrData_q;
    hrFull_d    = hrFull_q;
    selHr_d     = selHr_q;
    frame_d     = frame_q;
    lastIdx_d   = lastIdx_q;
    idx_d       = idx_q;
    txStart_d   = 1'b0;
    txData_d    = txData_q;
    frameDone_d = 1'b0;
    dropInc     = 2'd0;

    // A slot emptied by LOAD in this same cycle may take a new strobe without
    // counting a drop.
    consumeEcg = (state_q == LOAD) && !selHr_q;
    consumeHr  = (state_q == LOAD) && selHr_q;

    if (ecg_valid) begin
      ecgData_d = ecg_sample;
      ecgFull_d = 1'b1;
      if (ecgFull_q && !consumeEcg) dropInc = dropInc + 2'd1;
    end else if (consumeEcg) begin
      ecgFull_d = 1'b0;
    end

    if (hr_valid) begin
      hrData_d = {heart_rate, rr_interval};
      hrFull_d = 1'b1;
      if (hrFull_q && !consumeHr) dropInc = dropInc + 2'd1;
    end else if (consumeHr) begin
      hrFull_d = 1'b0;
    end

    dropSum   = {1'b0, dropCnt_q} + {7'd0, dropInc};
    dropCnt_d = dropSum[8] ? 8'hFF : dropSum[7:0];

    case (state_q)
      IDLE: begin
        // The HR source wins when both slots are full.
        selHr_d = hrFull_q;
      end
      LOAD: begin
        // Build the frame from the registered slot. A strobe arriving in this
        // same cycle only affects the next frame.
        idx_d      = 3'd0;
        frame_d[0] = SYNC_BYTE;
        if (selHr_q) begin
          frame_d[1] = TYPE_HR;
          frame_d[2] = hrData_q[31:24];
          frame_d[3] = hrData_q[23:16];
          frame_d[4] = hrData_q[15:8];
          frame_d[5] = hrData_q[7:0];
          frame_d[6] = TYPE_HR ^ hrData_q[31:24] ^ hrData_q[23:16]
                       ^ hrData_q[15:8] ^ hrData_q[7:0];
          lastIdx_d  = 3'd6;
        end else begin
          frame_d[1] = TYPE_ECG;
          frame_d[2] = ecgData_q[23:16];
          frame_d[3] = ecgData_q[15:8];
          frame_d[4] = ecgData_q[7:0];
          frame_d[5] = TYPE_ECG ^ ecgData_q[23:16] ^ ecgData_q[15:8]
                       ^ ecgData_q[7:0];
          frame_d[6] = 8'h00;
          lastIdx_d  = 3'd5;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          txStart_d = 1'b1;
          txData_d  = frame_q[idx_q];
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == lastIdx_q) frameDone_d = 1'b1;
          else                    idx_d = idx_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecgData_q   <= '0;
      ecgFull_q   <= 1'b0;
      hrData_q    <= '0;
      hrFull_q    <= 1'b0;
      selHr_q     <= 1'b0;
      for (int i = 0; i < 7; i++) frame_q[i] <= '0;
      lastIdx_q   <= '0;
      idx_q       <= '0;
      txStart_q   <= 1'b0;
      txData_q    <= '0;
      frameDone_q <= 1'b0;
      dropCnt_q   <= '0;
    end else begin
      ecgData_q   <= ecgData_d;
      ecgFull_q   <= ecgFull_d;
      hrData_q    <= hrData_d;
      hrFull_q    <= hrFull_d;
      selHr_q     <= selHr_d;
      frame_q     <= frame_d;
      lastIdx_q   <= lastIdx_d;
      idx_q       <= idx_d;
      txStart_q   <= txStart_d;
      txData_q    <= txData_d;
      frameDone_q <= frameDone_d;
      dropCnt_q   <= dropCnt_d;
    end
  end

  assign tx_start   = txStart_q;
  assign tx_data    = txData_q;
  assign frame_done = frameDone_q;
  assign drop_cnt   = dropCnt_q;

endmodule

// File: tb/tb_ecg_uart_scheduler.sv
// tb_ecg_uart_scheduler
//   Drives the scheduler with directed and random ECG / HR strobes. A simple
//   uart_tx stand-in stays busy for 10 cycles per byte and records every byte.
//   Expected byte streams come from the frame format and the slot rules.
module tb_ecg_uart_scheduler;

  localparam int BUSY_CYC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ecg_valid;
  logic [23:0] ecg_sample;
  logic        hr_valid;
  logic [15:0] heart_rate;
  logic [15:0] rr_interval;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] rxBytes[$];
  logic [7:0] expBytes[$];
  int frameDoneCnt = 0;
  int expFrameTotal = 0;
  int startWhileBusy = 0;
  int busyCnt = 0;
  int dropModel = 0;
  int lat;
  logic [23:0] lastSample;

  ecg_uart_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ecg_valid   (ecg_valid),
    .ecg_sample  (ecg_sample),
    .hr_valid    (hr_valid),
    .heart_rate  (heart_rate),
    .rr_interval (rr_interval),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .frame_done  (frame_done),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: raises busy one edge after it sees tx_start and holds it
  // for BUSY_CYC cycles. It also counts frame_done pulses.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busyCnt = 0;
      tx_busy <= 1'b0;
    end else begin
      if (tx_start && tx_busy) startWhileBusy++;
      if (tx_start) begin
        rxBytes.push_back(tx_data);
        busyCnt = BUSY_CYC;
        tx_busy <= 1'b1;
      end else if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) tx_busy <= 1'b0;
      end
      if (frame_done) frameDoneCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushEcg(input logic [23:0] s);
    expBytes.push_back(8'hA5);
    expBytes.push_back(8'h01);
    expBytes.push_back(s[23:16]);
    expBytes.push_back(s[15:8]);
    expBytes.push_back(s[7:0]);
    expBytes.push_back(8'h01 ^ s[23:16] ^ s[15:8] ^ s[7:0]);
    expFrameTotal++;
  endtask

  task automatic pushHr(input logic [15:0] h, input logic [15:0] r);
    expBytes.push_back(8'hA5);
    expBytes.push_back(8'h02);
    expBytes.push_back(h[15:8]);
    expBytes.push_back(h[7:0]);
    expBytes.push_back(r[15:8]);
    expBytes.push_back(r[7:0]);
    expBytes.push_back(8'h02 ^ h[15:8] ^ h[7:0] ^ r[15:8] ^ r[7:0]);
    expFrameTotal++;
  endtask

  task automatic applyStimulus(input bit doEcg, input bit doHr, input logic [23:0] s,
                               input logic [15:0] h, input logic [15:0] r);
    @(negedge clk);
    ecg_sample  = s;
    heart_rate  = h;
    rr_interval = r;
    ecg_valid   = doEcg;
    hr_valid    = doHr;
    @(negedge clk);
    ecg_valid   = 1'b0;
    hr_valid    = 1'b0;
  endtask

  // Counts active edges from the first edge after the caller's stimulus until
  // tx_start is seen high.
  task automatic measureLatency(output int l);
    l = 0;
    @(posedge clk);
    while (l < 20) begin
      @(negedge clk);
      ecg_valid = 1'b0;
      hr_valid  = 1'b0;
      if (tx_start) break;
      @(posedge clk);
      l++;
    end
  endtask

  task automatic waitFrames();
    int n = 0;
    while (frameDoneCnt < expFrameTotal && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (frameDoneCnt < expFrameTotal)
      checkOutput("frame_timeout", frameDoneCnt, expFrameTotal);
    repeat (3) @(negedge clk);
  endtask

  task automatic waitRx(input int count);
    int n = 0;
    while (rxBytes.size() < count && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rxBytes.size() < count) checkOutput("rx_timeout", rxBytes.size(), count);
  endtask

  task automatic checkStream(input string tag);
    int n;
    checkOutput({tag, "_len"}, rxBytes.size(), expBytes.size());
    checkOutput({tag, "_frames"}, frameDoneCnt, expFrameTotal);
    n = (rxBytes.size() < expBytes.size()) ? rxBytes.size() : expBytes.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), rxBytes[i], expBytes[i]);
    rxBytes.delete();
    expBytes.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ecg_valid = 1'b0; hr_valid = 1'b0;
    ecg_sample = '0; heart_rate = '0; rr_interval = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single ECG frame plus start latency
    $display("[TB] ECG frame");
    @(negedge clk);
    ecg_sample = 24'h123456;
    ecg_valid  = 1'b1;
    measureLatency(lat);
    checkOutput("ecg_latency", lat, 3);
    expBytes = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h71};
    expFrameTotal++;
    waitFrames();
    checkStream("t1");

    // 2: single HR frame
    $display("[TB] HR frame");
    applyStimulus(1'b0, 1'b1, 24'h0, 16'h0048, 16'h0341);
    expBytes = '{8'hA5, 8'h02, 8'h00, 8'h48, 8'h03, 8'h41, 8'h08};
    expFrameTotal++;
    waitFrames();
    checkStream("t2");

    // 3: simultaneous strobes, HR goes first
    $display("[TB] simultaneous strobes");
    applyStimulus(1'b1, 1'b1, 24'hABCDEF, 16'h1234, 16'h5678);
    pushHr(16'h1234, 16'h5678);
    pushEcg(24'hABCDEF);
    waitFrames();
    checkStream("t3");
    checkOutput("t3_drop", drop_cnt, 0);

    // 4: overwrites while a frame is in flight, then saturation
    $display("[TB] overwrites");
    applyStimulus(1'b1, 1'b0, 24'h000111, 16'h0, 16'h0);
    pushEcg(24'h000111);
    waitRx(1);
    applyStimulus(1'b1, 1'b0, 24'h000222, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 24'h000333, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 24'h000444, 16'h0, 16'h0);
    dropModel = 2;
    checkOutput("t4_drop2", drop_cnt, dropModel);
    pushEcg(24'h000444);
    waitFrames();
    checkStream("t4a");
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lastSample = 24'h500000 + 24'(i);
      ecg_sample = lastSample;
      ecg_valid  = 1'b1;
    end
    @(negedge clk);
    ecg_valid = 1'b0;
    dropModel = (dropModel + 299 > 255) ? 255 : dropModel + 299;
    checkOutput("t4_drop_sat", drop_cnt, dropModel);
    checkOutput("t4_hold_len", rxBytes.size(), 0);
    @(negedge clk);
    en = 1'b1;
    pushEcg(lastSample);
    waitFrames();
    checkStream("t4b");

    // 5: en dropped during byte 2
    $display("[TB] enable hold");
    applyStimulus(1'b1, 1'b0, 24'hC0FFEE, 16'h0, 16'h0);
    pushEcg(24'hC0FFEE);
    waitRx(2);
    @(negedge clk);
    en = 1'b0;
    applyStimulus(1'b1, 1'b0, 24'h0BEEF0, 16'h0, 16'h0);
    waitFrames();
    checkStream("t5a");
    repeat (40) @(negedge clk);
    checkOutput("t5_hold_len", rxBytes.size(), 0);
    @(negedge clk);
    en = 1'b1;
    measureLatency(lat);
    checkOutput("en_latency", lat, 2);
    pushEcg(24'h0BEEF0);
    waitFrames();
    checkStream("t5b");

    // 6: reset during byte 3
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0, 24'h765432, 16'h0, 16'h0);
    waitRx(3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_tx_start", tx_start, 0);
    checkOutput("t6_drop", drop_cnt, 0);
    checkOutput("t6_frame_done", frame_done, 0);
    rst = 1'b0;
    dropModel = 0;
    rxBytes.delete();
    repeat (40) @(negedge clk);
    checkOutput("t6_no_done", frameDoneCnt, expFrameTotal);
    checkOutput("t6_no_bytes", rxBytes.size(), 0);
    applyStimulus(1'b1, 1'b0, 24'h13579B, 16'h0, 16'h0);
    pushEcg(24'h13579B);
    waitFrames();
    checkStream("t6");

    // Random frames, each one allowed to drain before the next strobe.
    $display("[TB] random frames");
    for (int k = 0; k < 20; k++) begin
      int kind;
      logic [23:0] s;
      logic [15:0] h, r;
      kind = int'($urandom_range(0, 2));
      s = 24'($urandom);
      h = 16'($urandom);
      r = 16'($urandom);
      applyStimulus(kind != 1, kind != 0, s, h, r);
      if (kind != 0) pushHr(h, r);
      if (kind != 1) pushEcg(s);
      waitFrames();
      checkStream($sformatf("rnd%0d", k));
      checkOutput("rnd_drop", drop_cnt, dropModel);
    end

    checkOutput("start_while_busy", startWhileBusy, 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
